// File: rtl/fifo_word_packer.sv
// Packs RATIO FWFT FIFO entries (little-endian) into one wide word on a valid/ready port.
// A partial word with a lane mask is emitted on flush or after an idle timeout.
module fifo_word_packer #(
    parameter int unsigned IN_WIDTH = 8,
    parameter int unsigned RATIO    = 4,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fifo_empty,
    output logic                         fifo_rd_en,
    input  logic [IN_WIDTH-1:0]          fifo_dout,
    input  logic                         flush,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [IN_WIDTH*RATIO-1:0]    m_data,
    output logic [RATIO-1:0]             m_keep
);

    localparam int unsigned CW = $clog2(RATIO);
    localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned AW = (RATIO - 1) * IN_WIDTH;
    localparam logic [CW-1:0] LastLane = CW'(RATIO - 1);
    localparam logic [TW-1:0] TimerMax = TW'(TIMEOUT);

    logic [AW-1:0]             acc_q, acc_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [TW-1:0]             timer_q, timer_d;
    logic                      m_valid_d;
    logic [IN_WIDTH*RATIO-1:0] m_data_d;
    logic [RATIO-1:0]          m_keep_d;

    logic out_free, take, full, partial, load, timed_out;
    logic [IN_WIDTH*RATIO-1:0] word;
    logic [RATIO-1:0]          keep;

    always_comb begin
        out_free  = !m_valid || m_ready;
        take      = !fifo_empty && (cnt_q != LastLane || out_free);
        full      = take && (cnt_q == LastLane);
        timed_out = (TIMEOUT != 0) && (timer_q == TimerMax) && (cnt_q != '0);
        partial   = out_free && !full && ((flush && (cnt_q != '0 || take)) || timed_out);
        load      = full || partial;

        // Assemble filled lanes plus this cycle's pop; lanes beyond it stay zero.
        word  = '0;
        keep  = '0;
        acc_d = acc_q;
        for (int k = 0; k < RATIO - 1; k++) begin
            if (CW'(k) < cnt_q) begin
                word[k*IN_WIDTH +: IN_WIDTH] = acc_q[k*IN_WIDTH +: IN_WIDTH];
                keep[k]                      = 1'b1;
            end else if (take && CW'(k) == cnt_q) begin
                word[k*IN_WIDTH +: IN_WIDTH]  = fifo_dout;
                keep[k]                       = 1'b1;
                acc_d[k*IN_WIDTH +: IN_WIDTH] = fifo_dout;
            end
        end
        if (full) begin
            word[(RATIO-1)*IN_WIDTH +: IN_WIDTH] = fifo_dout;
            keep[RATIO-1]                        = 1'b1;
        end

        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (take) begin
            cnt_d = cnt_q + CW'(1);
        end

        timer_d = timer_q;
        if (take || load || cnt_q == '0) begin
            timer_d = '0;
        end else if (timer_q != TimerMax) begin
            timer_d = timer_q + TW'(1);
        end

        m_valid_d = m_valid;
        m_data_d  = m_data;
        m_keep_d  = m_keep;
        if (load) begin
            m_valid_d = 1'b1;
            m_data_d  = word;
            m_keep_d  = keep;
        end else if (m_valid && m_ready) begin
            m_valid_d = 1'b0;
        end

        fifo_rd_en = take;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            timer_q <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_keep  <= '0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            m_valid <= m_valid_d;
            m_data  <= m_data_d;
            m_keep  <= m_keep_d;
        end
    end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: directed scenarios plus randomized traffic checked against
// a queue-based model of the packing rules.
module tb_fifo_word_packer;

    localparam int unsigned IW = 8;
    localparam int unsigned R  = 4;
    localparam int unsigned TO = 16;
    localparam int unsigned W  = IW * R;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fifo_empty = 1'b1;
    logic [IW-1:0] fifo_dout = '0;
    logic          flush = 1'b0;
    logic          m_ready = 1'b0;
    logic          fifo_rd_en, m_valid;
    logic [W-1:0]  m_data;
    logic [R-1:0]  m_keep;
    logic          rd_en0, m_valid0;
    logic [W-1:0]  m_data0;
    logic [R-1:0]  m_keep0;

    int checks = 0;
    int failures = 0;

    logic [IW-1:0] src[$];
    logic [IW-1:0] mlanes[$];
    int            mtimer;
    logic          mvalid;
    logic [W-1:0]  mdata;
    logic [R-1:0]  mkeep;
    logic          exp_rd, rd_seen, rd0_seen;

    always #5 clk = ~clk;

    fifo_word_packer #(.IN_WIDTH(IW), .RATIO(R), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .fifo_dout(fifo_dout), .flush(flush), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_keep(m_keep)
    );

    fifo_word_packer #(.IN_WIDTH(IW), .RATIO(R), .TIMEOUT(0)) dut0 (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(rd_en0),
        .fifo_dout(fifo_dout), .flush(flush), .m_valid(m_valid0), .m_ready(m_ready),
        .m_data(m_data0), .m_keep(m_keep0)
    );

    task automatic model_clear();
        mlanes.delete();
        mtimer = 0;
        mvalid = 1'b0;
        mdata  = '0;
        mkeep  = '0;
    endtask

    // One clock: present the FIFO head, sample fifo_rd_en, advance the model, cross the edge.
    task automatic step();
        int   n;
        logic free, take, full, part;
        fifo_empty = (src.size() == 0);
        fifo_dout  = '0;
        if (!fifo_empty) fifo_dout = src[0];
        #1;
        rd_seen  = fifo_rd_en;
        rd0_seen = rd_en0;
        n    = mlanes.size();
        free = !mvalid || m_ready;
        take = !fifo_empty && (n < R - 1 || free);
        full = take && (n == R - 1);
        part = free && !full &&
               ((flush && (n > 0 || take)) || (TO > 0 && mtimer == TO && n > 0));
        exp_rd = take;
        if (take || full || part || n == 0) mtimer = 0;
        else if (mtimer < TO) mtimer++;
        if (take) mlanes.push_back(src[0]);
        if (full || part) begin
            mdata = '0;
            mkeep = '0;
            for (int k = 0; k < mlanes.size(); k++) begin
                mdata[k*IW +: IW] = mlanes[k];
                mkeep[k] = 1'b1;
            end
            mvalid = 1'b1;
            mlanes.delete();
        end else if (mvalid && m_ready) begin
            mvalid = 1'b0;
        end
        @(posedge clk);
        #1;
        if (take) void'(src.pop_front());
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        flush = 1'b0;
        src.delete();
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({m_valid, m_keep, m_data, fifo_rd_en} !== '0) begin
            failures++;
            $display("FAIL reset_state: got v=%b k=%h d=%h rd=%b, want all zero",
                     m_valid, m_keep, m_data, fifo_rd_en);
        end
        do_reset();
    endtask

    task automatic test_stream();
        do_reset();
        m_ready = 1'b1;
        for (int b = 1; b <= 8; b++) src.push_back(IW'(b * 8'h11));
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if ({rd_seen, m_valid, m_keep, m_data} !== {exp_rd, mvalid, mkeep, mdata}) begin
                failures++;
                $display("FAIL stream_model cyc%0d: got rd=%b v=%b k=%h d=%h want rd=%b v=%b k=%h d=%h",
                         i, rd_seen, m_valid, m_keep, m_data, exp_rd, mvalid, mkeep, mdata);
            end
            if (i < 8) begin
                checks++;
                if (rd_seen !== 1'b1) begin
                    failures++;
                    $display("FAIL stream_rd_en cyc%0d: got %b want 1", i, rd_seen);
                end
            end
            if (i == 3 || i == 7) begin
                checks++;
                if ({m_valid, m_keep, m_data} !== {1'b1, 4'hF, (i == 3) ? 32'h44332211 : 32'h88776655}) begin
                    failures++;
                    $display("FAIL stream_word cyc%0d: got v=%b k=%h d=%h", i, m_valid, m_keep, m_data);
                end
            end
            if (i == 4) begin
                checks++;
                if (m_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL stream_pulse: got v=%b want 0", m_valid);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        m_ready = 1'b0;
        for (int b = 1; b <= 8; b++) src.push_back(IW'(b * 8'h11));
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if ({rd_seen, m_valid, m_keep, m_data} !== {exp_rd, mvalid, mkeep, mdata}) begin
                failures++;
                $display("FAIL bp_model cyc%0d: got rd=%b v=%b k=%h d=%h want rd=%b v=%b k=%h d=%h",
                         i, rd_seen, m_valid, m_keep, m_data, exp_rd, mvalid, mkeep, mdata);
            end
        end
        checks++;
        if ({rd_seen, m_valid, m_data} !== {1'b0, 1'b1, 32'h44332211} || src.size() != 1) begin
            failures++;
            $display("FAIL bp_stall: got rd=%b v=%b d=%h left=%0d want rd=0 v=1 d=44332211 left=1",
                     rd_seen, m_valid, m_data, src.size());
        end
        m_ready = 1'b1;
        step();
        checks++;
        if ({rd_seen, m_valid, m_keep, m_data} !== {1'b1, 1'b1, 4'hF, 32'h88776655}) begin
            failures++;
            $display("FAIL bp_release: got rd=%b v=%b k=%h d=%h want rd=1 v=1 k=f d=88776655",
                     rd_seen, m_valid, m_keep, m_data);
        end
        step();
    endtask

    task automatic test_timeout();
        int emit_at;
        int v0_seen;
        do_reset();
        m_ready = 1'b1;
        src.push_back(8'hAA);
        src.push_back(8'hBB);
        step();
        step();
        emit_at = -1;
        v0_seen = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (m_valid0 || rd0_seen) v0_seen++;
            if (m_valid && emit_at < 0) begin
                emit_at = i;
                checks++;
                if ({m_keep, m_data} !== {4'h3, 32'h0000BBAA}) begin
                    failures++;
                    $display("FAIL timeout_word: got k=%h d=%h want k=3 d=0000bbaa", m_keep, m_data);
                end
            end
            checks++;
            if ({m_valid, m_keep, m_data} !== {mvalid, mkeep, mdata}) begin
                failures++;
                $display("FAIL timeout_model edge%0d: got v=%b k=%h d=%h want v=%b k=%h d=%h",
                         i, m_valid, m_keep, m_data, mvalid, mkeep, mdata);
            end
        end
        checks++;
        if (emit_at != 17) begin
            failures++;
            $display("FAIL timeout_latency: got edge %0d want edge 17", emit_at);
        end
        checks++;
        if (v0_seen != 0) begin
            failures++;
            $display("FAIL timeout_disabled: got %0d active cycles want 0", v0_seen);
        end
    endtask

    task automatic test_flush();
        do_reset();
        m_ready = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if ({m_valid, rd_seen} !== 2'b00) begin
            failures++;
            $display("FAIL flush_empty: got v=%b rd=%b want 0 0", m_valid, rd_seen);
        end
        src.push_back(8'h01); src.push_back(8'h02); src.push_back(8'h03);
        repeat (3) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if ({m_valid, m_keep, m_data} !== {1'b1, 4'h7, 32'h00030201}) begin
            failures++;
            $display("FAIL flush_three: got v=%b k=%h d=%h want v=1 k=7 d=00030201",
                     m_valid, m_keep, m_data);
        end
        step();
        src.push_back(8'h01); src.push_back(8'h02);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if ({m_valid, m_keep, m_data, rd_seen} !== {1'b1, 4'h3, 32'h00000201, 1'b1}) begin
            failures++;
            $display("FAIL flush_with_pop: got v=%b k=%h d=%h rd=%b want v=1 k=3 d=00000201 rd=1",
                     m_valid, m_keep, m_data, rd_seen);
        end
        step();
    endtask

    task automatic test_pending();
        logic [IW-1:0] bytes [6];
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            m_ready = 1'b0;
            bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hC1 + 8'(pass * 16), 8'hC2 + 8'(pass * 16)};
            for (int b = 0; b < 6; b++) src.push_back(bytes[b]);
            repeat (6) step();
            flush = (pass == 0);
            repeat ((pass == 0) ? 3 : 25) step();
            checks++;
            if ({m_valid, m_keep, m_data} !== {1'b1, 4'hF, 32'h44332211}) begin
                failures++;
                $display("FAIL pending_hold%0d: got v=%b k=%h d=%h want v=1 k=f d=44332211",
                         pass, m_valid, m_keep, m_data);
            end
            m_ready = 1'b1;
            step();
            flush = 1'b0;
            checks++;
            if ({m_valid, m_keep, m_data} !== {1'b1, 4'h3, 16'h0, bytes[5], bytes[4]}) begin
                failures++;
                $display("FAIL pending_emit%0d: got v=%b k=%h d=%h want v=1 k=3 d=0000%h%h",
                         pass, m_valid, m_keep, m_data, bytes[5], bytes[4]);
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        m_ready = 1'b1;
        for (int b = 1; b <= 5; b++) src.push_back(IW'(8'hA0 + b));
        repeat (2) step();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({m_valid, m_keep, m_data} !== '0) begin
            failures++;
            $display("FAIL reset_mid_word: got v=%b k=%h d=%h want 0", m_valid, m_keep, m_data);
        end
        @(negedge clk);
        rst = 1'b0;
        src.delete();
        model_clear();
        for (int b = 1; b <= 4; b++) src.push_back(IW'(8'hB0 + b));
        repeat (4) step();
        checks++;
        if ({m_valid, m_keep, m_data} !== {1'b1, 4'hF, 32'hB4B3B2B1}) begin
            failures++;
            $display("FAIL reset_clean_word: got v=%b k=%h d=%h want v=1 k=f d=b4b3b2b1",
                     m_valid, m_keep, m_data);
        end
        m_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({m_valid, m_keep, m_data} !== '0) begin
            failures++;
            $display("FAIL reset_mid_hold: got v=%b k=%h d=%h want 0", m_valid, m_keep, m_data);
        end
        @(negedge clk);
        rst = 1'b0;
        src.delete();
        model_clear();
    endtask

    task automatic test_random();
        int push_pct [3] = '{70, 10, 100};
        do_reset();
        for (int ph = 0; ph < 3; ph++) begin
            for (int i = 0; i < 200; i++) begin
                if ($urandom_range(99) < push_pct[ph] && src.size() < 16)
                    src.push_back(IW'($urandom));
                m_ready = ($urandom_range(99) < 70);
                flush   = ($urandom_range(99) < 4);
                step();
                checks++;
                if ({rd_seen, m_valid, m_keep, m_data} !== {exp_rd, mvalid, mkeep, mdata}) begin
                    failures++;
                    $display("FAIL random ph%0d cyc%0d: got rd=%b v=%b k=%h d=%h want rd=%b v=%b k=%h d=%h",
                             ph, i, rd_seen, m_valid, m_keep, m_data, exp_rd, mvalid, mkeep, mdata);
                end
            end
        end
        flush = 1'b0;
    endtask

    initial begin
        model_clear();
        test_reset();
        test_stream();
        test_backpressure();
        test_timeout();
        test_flush();
        test_pending();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
